bcd_stopwatch_counter: RTL and testbench

//  Multi-digit BCD time counter for the stopwatch datapath; generalises the 2-digit 0..99 counter.

---
 rtl/bcd_stopwatch_counter.sv | 169 ++++++++++++++++
 tb/tb_bcd_stopwatch_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_counter.sv
// Multi-digit BCD stopwatch counter with an IDLE/RUN/PAUSED control FSM, up/down counting, wrap or saturate.
// Optional lap capture is enabled by defining BCD_STOPWATCH_LAP_EN.
module bcd_stopwatch_counter #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clock,
  input  logic                nRST,
  input  logic                tick,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                up_down,
  output logic [4*DIGITS-1:0] number,
  output logic                running,
  output logic                carry_out,
  output logic                at_limit
`ifdef BCD_STOPWATCH_LAP_EN
  ,
  input  logic                lap,
  output logic [4*DIGITS-1:0] lap_number,
  output logic                lap_valid
`endif
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  function automatic logic [W-1:0] all_nines();
    logic [W-1:0] v;
    v = {W{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      v[4*i +: 4] = 4'd9;
    end
    return v;
  endfunction

  // One BCD step with full ripple; the MSB of the result is the wrap flag.
  function automatic logic [W:0] bcd_step(input logic [W-1:0] val, input logic up);
    logic [W-1:0] res;
    logic         c;
    logic [3:0]   d;
    res = val;
    c   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = val[4*i +: 4];
      if (!c) begin
        res[4*i +: 4] = d;
      end else if (up) begin
        if (d == 4'd9) begin
          res[4*i +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          res[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end else begin
        if (d == 4'd0) begin
          res[4*i +: 4] = 4'd9;
          c = 1'b1;
        end else begin
          res[4*i +: 4] = d - 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, res};
  endfunction

  localparam logic [W-1:0] ALL_NINES = all_nines();

  state_t         state_r, state_s;
  logic [W-1:0]   number_r, number_s, step_val_s;
  logic           wrap_s, carry_r, carry_s, running_r, running_s, count_en_s, at_limit_s;

  // State and datapath registers
  always_ff @(posedge clock or negedge nRST) begin
    if (!nRST) begin
      state_r   <= ST_IDLE;
      number_r  <= {W{1'b0}};
      carry_r   <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      number_r  <= number_s;
      carry_r   <= carry_s;
      running_r <= running_s;
    end
  end

  // Next-state logic: clear beats stop, stop beats start
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = ST_IDLE;
    end else if (stop) begin
      if (state_r == ST_RUN) begin
        state_s = ST_PAUSED;
      end else begin
        state_s = state_r;
      end
    end else if (start) begin
      state_s = ST_RUN;
    end else begin
      state_s = state_r;
    end
  end

  // Output and count decode; counting keys off the registered state
  always_comb begin
    number_s   = number_r;
    carry_s    = 1'b0;
    count_en_s = (state_r == ST_RUN) && tick && !clear;
    {wrap_s, step_val_s} = bcd_step(number_r, up_down);
    running_s  = (state_s == ST_RUN);
    at_limit_s = up_down ? (number_r == ALL_NINES) : (number_r == {W{1'b0}});
    if (clear) begin
      number_s = {W{1'b0}};
      carry_s  = 1'b0;
    end else if (count_en_s) begin
      if (wrap_s && SATURATE) begin
        number_s = number_r;
        carry_s  = 1'b0;
      end else begin
        number_s = step_val_s;
        carry_s  = wrap_s;
      end
    end else begin
      number_s = number_r;
      carry_s  = 1'b0;
    end
  end

  assign number    = number_r;
  assign running   = running_r;
  assign carry_out = carry_r;
  assign at_limit  = at_limit_s;

`ifdef BCD_STOPWATCH_LAP_EN
  logic [W-1:0] lap_number_r;
  logic         lap_valid_r;

  // Lap capture holds the pre-update count; ignored while IDLE
  always_ff @(posedge clock or negedge nRST) begin
    if (!nRST) begin
      lap_number_r <= {W{1'b0}};
      lap_valid_r  <= 1'b0;
    end else if (clear) begin
      lap_number_r <= {W{1'b0}};
      lap_valid_r  <= 1'b0;
    end else if (lap && (state_r != ST_IDLE)) begin
      lap_number_r <= number_r;
      lap_valid_r  <= 1'b1;
    end else begin
      lap_number_r <= lap_number_r;
      lap_valid_r  <= lap_valid_r;
    end
  end

  assign lap_number = lap_number_r;
  assign lap_valid  = lap_valid_r;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Self-checking bench: a wrapping and a saturating instance share stimulus; vector table plus model-driven sequences.
module tb_bcd_stopwatch_counter;

  logic clock = 1'b0;
  logic nRST = 1'b0;
  logic tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, up_down = 1'b1;
  logic [15:0] number_a, number_b;
  logic running_a, running_b, carry_a, carry_b, limit_a, limit_b;
`ifdef BCD_STOPWATCH_LAP_EN
  logic lap = 1'b0;
  logic [15:0] lap_number_a, lap_number_b;
  logic lap_valid_a, lap_valid_b;
`endif

  always #5 clock = ~clock;

  bcd_stopwatch_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_a (
    .clock(clock), .nRST(nRST), .tick(tick), .start(start), .stop(stop), .clear(clear),
    .up_down(up_down), .number(number_a), .running(running_a), .carry_out(carry_a), .at_limit(limit_a)
`ifdef BCD_STOPWATCH_LAP_EN
    , .lap(lap), .lap_number(lap_number_a), .lap_valid(lap_valid_a)
`endif
  );

  bcd_stopwatch_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_b (
    .clock(clock), .nRST(nRST), .tick(tick), .start(start), .stop(stop), .clear(clear),
    .up_down(up_down), .number(number_b), .running(running_b), .carry_out(carry_b), .at_limit(limit_b)
`ifdef BCD_STOPWATCH_LAP_EN
    , .lap(lap), .lap_number(lap_number_b), .lap_valid(lap_valid_b)
`endif
  );

  typedef struct {
    logic tick, start, stop, clear, up_down;
    logic [15:0] number;
    logic running, carry, at_limit;
  } vec_t;

  typedef struct {
    logic [15:0] number;
    logic running, carry, at_limit;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int errors = 0;
  int checks = 0;
  int cnt_a = 0, st_a = 0, cnt_b = 0, st_b = 0;
  vec_t vecs[17];

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = 16'd0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal reference model: state 0=IDLE 1=RUN 2=PAUSED
  task automatic model_step(input bit sat, inout int cnt, inout int st,
                            input logic t, input logic s, input logic p, input logic c, input logic ud,
                            output exp_t e);
    logic wrap;
    wrap = 1'b0;
    if (c) cnt = 0;
    else if (st == 1 && t) begin
      if (ud) begin
        if (cnt == 9999) begin
          if (!sat) begin cnt = 0; wrap = 1'b1; end
        end else cnt = cnt + 1;
      end else begin
        if (cnt == 0) begin
          if (!sat) begin cnt = 9999; wrap = 1'b1; end
        end else cnt = cnt - 1;
      end
    end
    if (c) st = 0;
    else if (p) begin
      if (st == 1) st = 2;
    end else if (s) st = 1;
    e.number   = to_bcd(cnt);
    e.running  = (st == 1);
    e.carry    = wrap;
    e.at_limit = ud ? (cnt == 9999) : (cnt == 0);
  endtask

  task automatic check_field(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [15:0] n,
                         input logic r, input logic c, input logic l);
    check_field({tag, ".number"}, n, e.number);
    check_field({tag, ".running"}, {15'd0, r}, {15'd0, e.running});
    check_field({tag, ".carry_out"}, {15'd0, c}, {15'd0, e.carry});
    check_field({tag, ".at_limit"}, {15'd0, l}, {15'd0, e.at_limit});
  endtask

  task automatic drive(input logic t, input logic s, input logic p, input logic c, input logic ud);
    exp_t ea, eb;
    @(negedge clock);
    tick = t; start = s; stop = p; clear = c; up_down = ud;
    model_step(1'b0, cnt_a, st_a, t, s, p, c, ud, ea);
    model_step(1'b1, cnt_b, st_b, t, s, p, c, ud, eb);
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clock);
    #1;
    compare("wrap", qa.pop_front(), number_a, running_a, carry_a, limit_a);
    compare("sat", qb.pop_front(), number_b, running_b, carry_b, limit_b);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    exp_t e;
    @(negedge clock);
    tick = v.tick; start = v.start; stop = v.stop; clear = v.clear; up_down = v.up_down;
    e.number = v.number; e.running = v.running; e.carry = v.carry; e.at_limit = v.at_limit;
    qa.push_back(e);
    @(posedge clock);
    #1;
    compare($sformatf("vec%0d", idx), qa.pop_front(), number_a, running_a, carry_a, limit_a);
  endtask

  task automatic check_zero(input string tag);
    exp_t e;
    e.number = 16'h0000; e.running = 1'b0; e.carry = 1'b0; e.at_limit = ~up_down;
    qa.push_back(e);
    qb.push_back(e);
    compare({tag, ".wrap"}, qa.pop_front(), number_a, running_a, carry_a, limit_a);
    compare({tag, ".sat"}, qb.pop_front(), number_b, running_b, carry_b, limit_b);
  endtask

  task automatic do_reset();
    @(negedge clock);
    tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; up_down = 1'b1;
    nRST = 1'b0;
    #1;
    check_zero("reset");
    cnt_a = 0; st_a = 0; cnt_b = 0; st_b = 0;
    @(negedge clock);
    nRST = 1'b1;
  endtask

  initial begin
    // tick start stop clear up_down | number running carry at_limit
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9999, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9999, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 17; i++) apply_vec(vecs[i], i);

    // Twelve ticks up from reset
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (12) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_field("twelve.number", number_a, 16'h0012);

    // Approach the top limit: wrap instance rolls over, saturating one holds
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (9998) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_field("sat_top.number", number_b, 16'h9999);
    check_field("sat_top.at_limit", {15'd0, limit_b}, 16'd1);

    // Down-count across digit borrow and through zero
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (100) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_field("borrow.number", number_a, 16'h0099);
    repeat (99) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clear with all other controls at 0042, then async reset mid-count
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (42) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    check_zero("async");
    cnt_a = 0; st_a = 0; cnt_b = 0; st_b = 0;
    @(negedge clock);
    nRST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef BCD_STOPWATCH_LAP_EN
    do_reset();
    lap = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_field("lap_idle.valid", {15'd0, lap_valid_a}, 16'd0);
    lap = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (7) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    lap = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    lap = 1'b0;
    check_field("lap.number", lap_number_a, 16'h0007);
    check_field("lap.valid", {15'd0, lap_valid_a}, 16'd1);
    check_field("lap.count", number_a, 16'h0008);
    lap = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    lap = 1'b0;
    check_field("lap_clear.valid", {15'd0, lap_valid_a}, 16'd0);
    check_field("lap_clear.number", lap_number_a, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
